// File: rtl/ahb_master_bus_requester_if.sv
// Bundle of the command-side and bus-side signals of one master requester.
// The master modport is the requester itself; slave is the arbiter/bus/local-logic side.
interface ahb_master_bus_requester_if #(
    parameter int ADDR_W    = 32,
    parameter int PRIOR_BIT = 2
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [ADDR_W-1:0]    cmd_addr;
    logic [2:0]           cmd_burst;
    logic                 cmd_write;
    logic                 hreq;
    logic [PRIOR_BIT-1:0] hprior;
    logic                 hgrant;
    logic                 hwait;
    logic [ADDR_W-1:0]    haddr;
    logic [1:0]           htrans;
    logic [2:0]           hburst;
    logic                 hwrite;
    logic                 beat_done;
    logic                 xfer_done;

    modport master (
        input  cmd_valid, cmd_addr, cmd_burst, cmd_write, hgrant, hwait,
        output cmd_ready, hreq, hprior, haddr, htrans, hburst, hwrite, beat_done, xfer_done
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_burst, cmd_write, hgrant, hwait,
        input  cmd_ready, hreq, hprior, haddr, htrans, hburst, hwrite, beat_done, xfer_done
    );
endinterface

// File: rtl/ahb_master_bus_requester.sv
// Master-side bus requester: takes one burst command, requests the bus, drives address beats.
// Optional hprior aging is enabled by defining PRIORITY_AGING_EN.
module ahb_master_bus_requester #(
    parameter int ADDR_W        = 32,
    parameter int PRIOR_BIT     = 2,
    parameter int DEFAULT_PRIOR = 0,
    parameter int AGE_LIMIT     = 8
) (
    input  logic                              hclk,
    input  logic                              hreset_n,
    ahb_master_bus_requester_if.master        bus_io
);

    if (AGE_LIMIT < 1) begin : g_bad_age_limit
        $error("AGE_LIMIT must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_XFER
    } state_e;

    typedef enum logic [1:0] {
        TR_IDLE   = 2'b00,
        TR_NONSEQ = 2'b10,
        TR_SEQ    = 2'b11
    } htrans_e;

    state_e            state_q, state_d;
    htrans_e           htrans_q, htrans_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        burst_q, burst_d;
    logic              write_q, write_d;
    logic [3:0]        beat_cnt_q, beat_cnt_d;
    logic              beat_done_q, beat_done_d;
    logic              xfer_done_q, xfer_done_d;

    logic [3:0]        last_idx;
    logic [ADDR_W-1:0] wrap_mask;
    logic [ADDR_W-1:0] incr_addr;
    logic [ADDR_W-1:0] next_addr;
    logic              is_wrap;
    logic              beat_acc;

    // INCR is treated as a single beat, so only the size field matters here.
    always_comb begin
        unique case (burst_q[2:1])
            2'd0:    last_idx = 4'd0;
            2'd1:    last_idx = 4'd3;
            2'd2:    last_idx = 4'd7;
            default: last_idx = 4'd15;
        endcase
    end

    assign is_wrap   = (burst_q != 3'd0) && !burst_q[0];
    assign wrap_mask = ADDR_W'({last_idx, 2'b11});
    assign incr_addr = addr_q + ADDR_W'(4);
    assign next_addr = is_wrap ? ((addr_q & ~wrap_mask) | (incr_addr & wrap_mask)) : incr_addr;

    // A beat only counts when one is actually on the bus (not during a lost-grant gap).
    assign beat_acc  = (state_q == ST_XFER) && (htrans_q != TR_IDLE) &&
                       bus_io.hgrant && !bus_io.hwait;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path infers a latch.
        state_d     = state_q;
        htrans_d    = htrans_q;
        addr_d      = addr_q;
        burst_d     = burst_q;
        write_d     = write_q;
        beat_cnt_d  = beat_cnt_q;
        beat_done_d = 1'b0;
        xfer_done_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus_io.cmd_valid) begin
                    state_d    = ST_REQ;
                    addr_d     = bus_io.cmd_addr & ~ADDR_W'(3);
                    burst_d    = bus_io.cmd_burst;
                    write_d    = bus_io.cmd_write;
                    beat_cnt_d = '0;
                end
            end
            ST_REQ: begin
                if (bus_io.hgrant) begin
                    state_d  = ST_XFER;
                    htrans_d = TR_NONSEQ;
                end
            end
            ST_XFER: begin
                if (htrans_q == TR_IDLE) begin
                    if (bus_io.hgrant) htrans_d = TR_NONSEQ;
                end else if (beat_acc) begin
                    beat_done_d = 1'b1;
                    if (beat_cnt_q == last_idx) begin
                        xfer_done_d = 1'b1;
                        state_d     = ST_IDLE;
                        htrans_d    = TR_IDLE;
                        beat_cnt_d  = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 4'd1;
                        addr_d     = next_addr;
                        htrans_d   = TR_SEQ;
                    end
                end else if (!bus_io.hwait) begin
                    htrans_d = TR_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state_q     <= ST_IDLE;
            htrans_q    <= TR_IDLE;
            addr_q      <= '0;
            burst_q     <= '0;
            write_q     <= 1'b0;
            beat_cnt_q  <= '0;
            beat_done_q <= 1'b0;
            xfer_done_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values together.
            state_q     <= state_d;
            htrans_q    <= htrans_d;
            addr_q      <= addr_d;
            burst_q     <= burst_d;
            write_q     <= write_d;
            beat_cnt_q  <= beat_cnt_d;
            beat_done_q <= beat_done_d;
            xfer_done_q <= xfer_done_d;
        end
    end

`ifdef PRIORITY_AGING_EN
    localparam int WAIT_W = $clog2(AGE_LIMIT + 1);

    logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic [PRIOR_BIT-1:0] prior_q, prior_d;
    logic                 waiting;

    // Waiting covers both the initial request and a lost-grant gap inside a burst.
    assign waiting = ((state_q == ST_REQ) || ((state_q == ST_XFER) && (htrans_q == TR_IDLE))) &&
                     !bus_io.hgrant;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        prior_d    = prior_q;
        if ((state_q == ST_IDLE) || beat_acc) begin
            wait_cnt_d = '0;
            prior_d    = PRIOR_BIT'(DEFAULT_PRIOR);
        end else if (waiting) begin
            if (wait_cnt_q == WAIT_W'(AGE_LIMIT - 1)) begin
                wait_cnt_d = '0;
                if (prior_q != '1) prior_d = prior_q + 1'b1;
            end else begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            wait_cnt_q <= '0;
            prior_q    <= PRIOR_BIT'(DEFAULT_PRIOR);
        end else begin
            wait_cnt_q <= wait_cnt_d;
            prior_q    <= prior_d;
        end
    end

    assign bus_io.hprior = prior_q;
`else
    assign bus_io.hprior = PRIOR_BIT'(DEFAULT_PRIOR);
`endif

    assign bus_io.cmd_ready = (state_q == ST_IDLE);
    assign bus_io.hreq      = (state_q != ST_IDLE);
    assign bus_io.haddr     = addr_q;
    assign bus_io.htrans    = htrans_q;
    assign bus_io.hburst    = burst_q;
    assign bus_io.hwrite    = write_q;
    assign bus_io.beat_done = beat_done_q;
    assign bus_io.xfer_done = xfer_done_q;

endmodule

// File: tb/tb_ahb_master_bus_requester.sv
// Self-checking bench for ahb_master_bus_requester: directed scenarios then random traffic,
// all compared against a transaction-level model of the requester.
module tb_ahb_master_bus_requester;

    localparam int ADDR_W    = 32;
    localparam int PRIOR_BIT = 2;
    localparam int AGE_LIMIT = 8;

    logic hclk;
    logic hreset_n;

    ahb_master_bus_requester_if #(.ADDR_W(ADDR_W), .PRIOR_BIT(PRIOR_BIT)) bus_if ();

    ahb_master_bus_requester #(
        .ADDR_W       (ADDR_W),
        .PRIOR_BIT    (PRIOR_BIT),
        .DEFAULT_PRIOR(0),
        .AGE_LIMIT    (AGE_LIMIT)
    ) dut (
        .hclk    (hclk),
        .hreset_n(hreset_n),
        .bus_io  (bus_if.master)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: one outstanding command described as a list of beat addresses.
    logic        m_busy;
    logic        m_granted;
    logic        m_fresh;
    logic        m_started;
    int          m_idx;
    int          m_n;
    int          m_wait;
    logic [2:0]  m_burst;
    logic        m_write;
    logic        m_beat_done;
    logic        m_xfer_done;
    logic [31:0] m_addrs [16];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int nbeats(input logic [2:0] b);
        case (b)
            3'd0, 3'd1: return 1;
            3'd2, 3'd3: return 4;
            3'd4, 3'd5: return 8;
            default:    return 16;
        endcase
    endfunction

    function automatic void model_reset();
        m_busy      = 1'b0;
        m_granted   = 1'b0;
        m_fresh     = 1'b1;
        m_started   = 1'b0;
        m_idx       = 0;
        m_n         = 1;
        m_wait      = 0;
        m_burst     = 3'd0;
        m_write     = 1'b0;
        m_beat_done = 1'b0;
        m_xfer_done = 1'b0;
    endfunction

    function automatic void model_load(input logic [31:0] a, input logic [2:0] b);
        logic [31:0] a0, span, base;
        logic        wrap;
        a0   = a & 32'hFFFF_FFFC;
        m_n  = nbeats(b);
        span = 32'(4 * m_n);
        wrap = (b == 3'd2) || (b == 3'd4) || (b == 3'd6);
        base = a0 - (a0 % span);
        for (int i = 0; i < 16; i++) begin
            if (wrap) m_addrs[i] = base + ((a0 - base + 32'(4 * i)) % span);
            else      m_addrs[i] = a0 + 32'(4 * i);
        end
    endfunction

    // Advance the model across one rising edge given the inputs sampled there.
    function automatic void model_edge(input logic v, input logic [31:0] a, input logic [2:0] b,
                                       input logic wr, input logic g, input logic w);
        m_beat_done = 1'b0;
        m_xfer_done = 1'b0;
        if (!m_busy) begin
            if (v) begin
                model_load(a, b);
                m_busy    = 1'b1;
                m_burst   = b;
                m_write   = wr;
                m_idx     = 0;
                m_granted = 1'b0;
                m_fresh   = 1'b1;
                m_started = 1'b0;
                m_wait    = 0;
            end
        end else if (!m_granted) begin
            if (g) begin
                m_granted = 1'b1;
                m_started = 1'b1;
            end else begin
                m_wait++;
            end
        end else if (g && !w) begin
            m_beat_done = 1'b1;
            m_idx++;
            m_fresh = 1'b0;
            m_wait  = 0;
            if (m_idx == m_n) begin
                m_xfer_done = 1'b1;
                m_busy      = 1'b0;
                m_granted   = 1'b0;
            end
        end else if (!g && !w) begin
            m_granted = 1'b0;
            m_fresh   = 1'b1;
        end
    endfunction

    function automatic logic [31:0] exp_prior();
`ifdef PRIORITY_AGING_EN
        int p;
        p = m_wait / AGE_LIMIT;
        if (p > (2 ** PRIOR_BIT) - 1) p = (2 ** PRIOR_BIT) - 1;
        return 32'(p);
`else
        return 32'd0;
`endif
    endfunction

    task automatic compare_all();
        logic [1:0] exp_trans;
        exp_trans = !m_granted ? 2'b00 : (m_fresh ? 2'b10 : 2'b11);
        check("cmd_ready", 32'(bus_if.cmd_ready), 32'(!m_busy));
        check("hreq",      32'(bus_if.hreq),      32'(m_busy));
        check("htrans",    32'(bus_if.htrans),    32'(exp_trans));
        if (m_busy && m_started) check("haddr", bus_if.haddr, m_addrs[m_idx]);
        check("hburst",    32'(bus_if.hburst),    32'(m_burst));
        check("hwrite",    32'(bus_if.hwrite),    32'(m_write));
        check("beat_done", 32'(bus_if.beat_done), 32'(m_beat_done));
        check("xfer_done", 32'(bus_if.xfer_done), 32'(m_xfer_done));
        check("hprior",    32'(bus_if.hprior),    exp_prior());
    endtask

    // Called just after a falling edge: apply inputs, then compare after the next falling edge.
    task automatic cycle(input logic v, input logic [31:0] a, input logic [2:0] b,
                         input logic wr, input logic g, input logic w);
        bus_if.cmd_valid = v;
        bus_if.cmd_addr  = a;
        bus_if.cmd_burst = b;
        bus_if.cmd_write = wr;
        bus_if.hgrant    = g;
        bus_if.hwait     = w;
        model_edge(v, a, b, wr, g, w);
        @(negedge hclk);
        compare_all();
    endtask

    task automatic bus_cycles(input int n, input logic g, input logic w);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, 3'd0, 1'b0, g, w);
    endtask

    task automatic reset_now();
        #2 hreset_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("rst_haddr", bus_if.haddr, 32'd0);
        bus_if.cmd_valid = 1'b0;
        bus_if.hgrant    = 1'b0;
        bus_if.hwait     = 1'b0;
        @(negedge hclk);
        compare_all();
        hreset_n = 1'b1;
    endtask

    initial begin
        int          grant_pct;
        logic [2:0]  rb;
        logic [31:0] ra;
        logic        rw, rg, rv;

        hreset_n         = 1'b0;
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_addr  = '0;
        bus_if.cmd_burst = '0;
        bus_if.cmd_write = 1'b0;
        bus_if.hgrant    = 1'b0;
        bus_if.hwait     = 1'b0;
        model_reset();
        #3;
        compare_all();
        check("rst_haddr", bus_if.haddr, 32'd0);
        @(negedge hclk);
        @(negedge hclk);
        hreset_n = 1'b1;

        // SINGLE write at 0x100, grant two cycles after hreq rises.
        cycle(1'b1, 32'h100, 3'd0, 1'b1, 1'b0, 1'b0);
        bus_cycles(2, 1'b0, 1'b0);
        bus_cycles(2, 1'b1, 1'b0);
        bus_cycles(2, 1'b0, 1'b0);

        // INCR4 read at 0x10, slave stalls the second beat for three cycles.
        cycle(1'b1, 32'h10, 3'd3, 1'b0, 1'b0, 1'b0);
        bus_cycles(2, 1'b1, 1'b0);
        bus_cycles(3, 1'b0, 1'b1);
        bus_cycles(3, 1'b1, 1'b0);
        bus_cycles(2, 1'b0, 1'b0);

        // WRAP8 at 0x38 wraps inside the 32-byte window.
        cycle(1'b1, 32'h38, 3'd4, 1'b1, 1'b1, 1'b0);
        bus_cycles(9, 1'b1, 1'b0);
        bus_cycles(2, 1'b0, 1'b0);

        // INCR16 at 0x0 with the grant removed after five beats.
        cycle(1'b1, 32'h0, 3'd7, 1'b0, 1'b0, 1'b0);
        bus_cycles(6, 1'b1, 1'b0);
        bus_cycles(4, 1'b0, 1'b0);
        bus_cycles(12, 1'b1, 1'b0);
        bus_cycles(2, 1'b0, 1'b0);

        // Long wait for grant exercises priority aging when it is built in.
        cycle(1'b1, 32'h200, 3'd0, 1'b0, 1'b0, 1'b0);
        bus_cycles(20, 1'b0, 1'b0);
        bus_cycles(3, 1'b1, 1'b0);

        // Reset while the third beat of an INCR8 is on the bus, then a clean SINGLE.
        cycle(1'b1, 32'h400, 3'd5, 1'b1, 1'b0, 1'b0);
        bus_cycles(3, 1'b1, 1'b0);
        check("pre_rst_haddr", bus_if.haddr, 32'h408);
        reset_now();
        bus_cycles(2, 1'b0, 1'b0);
        cycle(1'b1, 32'h300, 3'd0, 1'b1, 1'b0, 1'b0);
        bus_cycles(4, 1'b1, 1'b0);

        // Random traffic with a grant probability that changes every block.
        grant_pct = 90;
        for (int t = 0; t < 3000; t++) begin
            if (t % 50 == 0) begin
                case ($urandom_range(0, 2))
                    0:       grant_pct = 8;
                    1:       grant_pct = 60;
                    default: grant_pct = 95;
                endcase
            end
            rb = 3'($urandom_range(0, 7));
            ra = $urandom;
            ra[9:2] = 8'($urandom_range(0, 256 - nbeats(rb)));
            rw = 1'($urandom);
            rv = ($urandom_range(0, 99) < 50);
            if ($urandom_range(0, 99) < 20) begin
                cycle(rv, ra, rb, rw, 1'b0, 1'b1);
            end else begin
                rg = ($urandom_range(0, 99) < grant_pct);
                cycle(rv, ra, rb, rw, rg, 1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
